// File: rtl/central_fuzzer_ctrl_pkg.sv
// Shared types for the central fuzzer controller: FSM states, log entry
// layout and the per-IP result width.
package central_fuzzer_pkg;

  localparam int IP_OUT_W = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_ACK,
    ST_RECORD,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [3:0]          ip;
    logic                crash;
    logic                hang;
    logic [IP_OUT_W-1:0] value;
  } log_entry_t;

  // Campaign counters stick at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/central_fuzzer_ctrl_log_fifo.sv
// First-word-fall-through log FIFO. The head reads as zero while empty so the
// log outputs are clean after reset.
module fuzz_log_fifo
  import central_fuzzer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  log_entry_t data_i,
  input  logic       pop_i,
  output log_entry_t head_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);

  log_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/central_fuzzer_ctrl.sv
// Central fuzzer controller: polls each unmasked local fuzzer in ascending
// order for a number of rounds, logging every result.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | waiting for start; counts hold last campaign's values
//   ST_SELECT   | find next masked IP at/after pointer, or end a round
//   ST_WAIT_ACK | enable high on selected IP, timing out towards a hang
//   ST_RECORD   | push captured result; stall here while the log is full
//   ST_DONE     | one-cycle done pulse, then back to idle
module central_fuzzer_ctrl
  import central_fuzzer_pkg::*;
#(
  parameter int NUM_IPS     = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int LOG_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 rounds,
  input  logic [NUM_IPS-1:0]          ip_mask,
  output logic [NUM_IPS-1:0]          fz_enable,
  input  logic [NUM_IPS-1:0]          fz_ack,
  input  logic [NUM_IPS-1:0]          fz_crash,
  input  logic [NUM_IPS*IP_OUT_W-1:0] fz_ip_output,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 crash_count,
  output logic [15:0]                 hang_count,
  input  logic                        log_rd,
  output logic                        log_valid,
  output logic [3:0]                  log_ip,
  output logic                        log_crash,
  output logic                        log_hang,
  output logic [IP_OUT_W-1:0]         log_value,
  output logic                        log_full
);

  localparam int TW = $clog2(ACK_TIMEOUT);

  state_e                state_q, state_d;
  logic [15:0]           rounds_q, rounds_d;
  logic [NUM_IPS-1:0]    mask_q, mask_d;
  logic [4:0]            ptr_q, ptr_d;
  logic [3:0]            sel_q, sel_d;
  logic [NUM_IPS-1:0]    enable_q, enable_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  crash_q, crash_d;
  logic                  hang_q, hang_d;
  logic [IP_OUT_W-1:0]   value_q, value_d;
  logic [15:0]           crash_cnt_q, crash_cnt_d;
  logic [15:0]           hang_cnt_q, hang_cnt_d;

  logic                  found;
  logic [3:0]            found_idx;
  logic                  ack_sel;
  logic                  crash_sel;
  logic [IP_OUT_W-1:0]   value_sel;
  logic                  push;
  logic                  fifo_empty;
  logic                  fifo_full;
  log_entry_t            push_entry;
  log_entry_t            head;

  // Lowest masked IP at or above the pointer (scan downwards so the last hit wins).
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_IPS - 1; i >= 0; i--) begin
      if (mask_q[i] && (5'(i) >= ptr_q)) begin
        found     = 1'b1;
        found_idx = 4'(i);
      end
    end
  end

  // Route the selected IP's handshake inputs; other IPs' acks are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    crash_sel = 1'b0;
    value_sel = '0;
    for (int i = 0; i < NUM_IPS; i++) begin
      if (4'(i) == sel_q) begin
        ack_sel   = fz_ack[i];
        crash_sel = fz_crash[i];
        value_sel = fz_ip_output[i*IP_OUT_W +: IP_OUT_W];
      end
    end
  end

  // Next-state and datapath updates for the polling FSM.
  always_comb begin
    state_d     = state_q;
    rounds_d    = rounds_q;
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    enable_d    = enable_q;
    timer_d     = timer_q;
    crash_d     = crash_q;
    hang_d      = hang_q;
    value_d     = value_q;
    crash_cnt_d = crash_cnt_q;
    hang_cnt_d  = hang_cnt_q;
    push        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rounds_d    = rounds;
          mask_d      = ip_mask;
          ptr_d       = '0;
          crash_cnt_d = '0;
          hang_cnt_d  = '0;
          state_d     = (rounds == 16'd0 || ip_mask == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (found) begin
          sel_d   = found_idx;
          timer_d = '0;
          for (int i = 0; i < NUM_IPS; i++) enable_d[i] = (4'(i) == found_idx);
          state_d = ST_WAIT_ACK;
        end else begin
          // End of a pass: the next SELECT rescans from IP 0.
          ptr_d    = '0;
          rounds_d = rounds_q - 16'd1;
          if (rounds_q == 16'd1) state_d = ST_DONE;
        end
      end
      ST_WAIT_ACK: begin
        // Ack is checked first so it wins over a same-cycle expiry.
        if (ack_sel) begin
          crash_d  = crash_sel;
          hang_d   = 1'b0;
          value_d  = value_sel;
          enable_d = '0;
          state_d  = ST_RECORD;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          crash_d  = 1'b0;
          hang_d   = 1'b1;
          value_d  = '0;
          enable_d = '0;
          state_d  = ST_RECORD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RECORD: begin
        // Wait for a free slot rather than drop a result.
        if (!fifo_full) begin
          push = 1'b1;
          if (hang_q)       hang_cnt_d  = sat_inc16(hang_cnt_q);
          else if (crash_q) crash_cnt_d = sat_inc16(crash_cnt_q);
          ptr_d   = {1'b0, sel_q} + 5'd1;
          state_d = ST_SELECT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rounds_q    <= '0;
      mask_q      <= '0;
      ptr_q       <= '0;
      sel_q       <= '0;
      enable_q    <= '0;
      timer_q     <= '0;
      crash_q     <= 1'b0;
      hang_q      <= 1'b0;
      value_q     <= '0;
      crash_cnt_q <= '0;
      hang_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rounds_q    <= rounds_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      enable_q    <= enable_d;
      timer_q     <= timer_d;
      crash_q     <= crash_d;
      hang_q      <= hang_d;
      value_q     <= value_d;
      crash_cnt_q <= crash_cnt_d;
      hang_cnt_q  <= hang_cnt_d;
    end
  end

  assign push_entry = '{ip: sel_q, crash: crash_q, hang: hang_q, value: value_q};

  fuzz_log_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (log_rd),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign fz_enable   = enable_q;
  assign busy        = (state_q == ST_SELECT) || (state_q == ST_WAIT_ACK) ||
                       (state_q == ST_RECORD);
  assign done        = (state_q == ST_DONE);
  assign crash_count = crash_cnt_q;
  assign hang_count  = hang_cnt_q;
  assign log_valid   = !fifo_empty;
  assign log_full    = fifo_full;
  assign log_ip      = head.ip;
  assign log_crash   = head.crash;
  assign log_hang    = head.hang;
  assign log_value   = head.value;

endmodule

// File: tb/tb_central_fuzzer_ctrl.sv
// Bench for central_fuzzer_ctrl: behavioural local fuzzers answer the
// enable/ack handshake, expected log entries go into a scoreboard queue.
module tb_central_fuzzer_ctrl;
  import central_fuzzer_pkg::*;

  localparam int NUM_IPS     = 4;
  localparam int ACK_TIMEOUT = 255;
  localparam int LOG_DEPTH   = 8;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        start = 1'b0;
  logic [15:0]                 rounds = '0;
  logic [NUM_IPS-1:0]          ip_mask = '0;
  logic [NUM_IPS-1:0]          fz_enable;
  logic [NUM_IPS-1:0]          fz_ack = '0;
  logic [NUM_IPS-1:0]          fz_crash = '0;
  logic [NUM_IPS*IP_OUT_W-1:0] fz_ip_output = '0;
  logic                        busy, done;
  logic [15:0]                 crash_count, hang_count;
  logic                        log_rd = 1'b0;
  logic                        log_valid, log_crash, log_hang, log_full;
  logic [3:0]                  log_ip;
  logic [IP_OUT_W-1:0]         log_value;

  int vectors = 0;
  int miscompares = 0;

  log_entry_t exp_q[$];
  int ack_delay [NUM_IPS];
  int rsp_cnt   [NUM_IPS];
  int en_cycles [NUM_IPS];
  int done_cnt = 0;
  int onehot_bad = 0;
  logic [NUM_IPS-1:0] en_seen = '0;

  central_fuzzer_ctrl #(
    .NUM_IPS(NUM_IPS), .ACK_TIMEOUT(ACK_TIMEOUT), .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rounds(rounds), .ip_mask(ip_mask),
    .fz_enable(fz_enable), .fz_ack(fz_ack), .fz_crash(fz_crash),
    .fz_ip_output(fz_ip_output), .busy(busy), .done(done),
    .crash_count(crash_count), .hang_count(hang_count), .log_rd(log_rd),
    .log_valid(log_valid), .log_ip(log_ip), .log_crash(log_crash),
    .log_hang(log_hang), .log_value(log_value), .log_full(log_full)
  );

  always #5 clk = ~clk;

  // Local fuzzer models: ack once after ack_delay enabled cycles (-1 = never).
  initial begin
    for (int i = 0; i < NUM_IPS; i++) begin
      rsp_cnt[i] = 0;
      ack_delay[i] = -1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_IPS; i++) begin
        if (fz_enable[i]) begin
          rsp_cnt[i]++;
          fz_ack[i] = (rsp_cnt[i] == ack_delay[i]);
        end else begin
          rsp_cnt[i] = 0;
          fz_ack[i] = 1'b0;
        end
      end
    end
  end

  // Passive monitor: done pulses, enable activity and one-hot property.
  initial begin
    for (int i = 0; i < NUM_IPS; i++) en_cycles[i] = 0;
    forever begin
      @(negedge clk);
      #1;
      if (done) done_cnt++;
      en_seen |= fz_enable;
      for (int i = 0; i < NUM_IPS; i++) if (fz_enable[i]) en_cycles[i]++;
      if ($countones(fz_enable) > 1) onehot_bad++;
    end
  end

  task automatic clear_mon();
    done_cnt = 0;
    en_seen = '0;
    for (int i = 0; i < NUM_IPS; i++) en_cycles[i] = 0;
  endtask

  task automatic set_ip(input int i, input int dly, input logic cr, input logic [IP_OUT_W-1:0] v);
    ack_delay[i] = dly;
    fz_crash[i] = cr;
    fz_ip_output[i*IP_OUT_W +: IP_OUT_W] = v;
  endtask

  task automatic push_exp(input int ip, input logic cr, input logic hg, input logic [IP_OUT_W-1:0] v);
    log_entry_t e;
    e.ip = 4'(ip);
    e.crash = cr;
    e.hang = hg;
    e.value = v;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic pulse_start(input logic [15:0] r, input logic [NUM_IPS-1:0] m);
    start = 1'b1;
    rounds = r;
    ip_mask = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done) break;
      @(negedge clk);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic drain_log(input string tag, input int max);
    log_entry_t got, e;
    for (int k = 0; k < max && log_valid; k++) begin
      got.ip = log_ip;
      got.crash = log_crash;
      got.hang = log_hang;
      got.value = log_value;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s extra_entry: got ip=%0d crash=%0b hang=%0b value=%h, expected none",
                 tag, got.ip, got.crash, got.hang, got.value);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s entry: got ip=%0d crash=%0b hang=%0b value=%h, expected ip=%0d crash=%0b hang=%0b value=%h",
                   tag, got.ip, got.crash, got.hang, got.value, e.ip, e.crash, e.hang, e.value);
        end
      end
      log_rd = 1'b1;
      @(negedge clk);
      log_rd = 1'b0;
    end
  endtask

  task automatic check_all_drained(input string tag);
    vectors++;
    if (exp_q.size() !== 0 || log_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s drained: %0d entries missing, log_valid=%0b, expected 0 and 0",
               tag, exp_q.size(), log_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (fz_enable !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: enable=%b busy=%b done=%b, expected 0 0 0", fz_enable, busy, done);
    end
    vectors++;
    if (crash_count !== 16'd0 || hang_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_counts: crash=%0d hang=%0d, expected 0 0", crash_count, hang_count);
    end
    vectors++;
    if ({log_valid, log_full, log_ip, log_crash, log_hang, log_value} !== '0) begin
      miscompares++;
      $display("FAIL reset_log: valid=%b full=%b ip=%0d c=%b h=%b v=%h, expected all 0",
               log_valid, log_full, log_ip, log_crash, log_hang, log_value);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_mon();
    set_ip(0, 5, 1'b0, 33'h0_0000_0042);
    set_ip(1, -1, 1'b1, 33'h0_DEAD_0001);
    set_ip(2, 3, 1'b1, 33'h1_FFFF_FFFF);
    set_ip(3, -1, 1'b1, 33'h0_DEAD_0003);
    push_exp(0, 1'b0, 1'b0, 33'h0_0000_0042);
    push_exp(2, 1'b1, 1'b0, 33'h1_FFFF_FFFF);
    pulse_start(16'd1, 4'b0101);
    vectors++;
    if (busy !== 1'b1 || fz_enable !== 4'b0000) begin
      miscompares++;
      $display("FAIL basic_select: busy=%b enable=%b, expected 1 0000", busy, fz_enable);
    end
    @(negedge clk);
    vectors++;
    if (fz_enable !== 4'b0001) begin
      miscompares++;
      $display("FAIL basic_latency: enable=%b, expected 0001", fz_enable);
    end
    wait_done("basic", 100);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || crash_count !== 16'd1 || hang_count !== 16'd0) begin
      miscompares++;
      $display("FAIL basic_counts: busy=%b crash=%0d hang=%0d, expected 0 1 0", busy, crash_count, hang_count);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt !== 1 || (en_seen & 4'b1010) !== 4'b0000) begin
      miscompares++;
      $display("FAIL basic_pulses: done_cnt=%0d en_seen=%b, expected 1 and no ip1/ip3", done_cnt, en_seen);
    end
    drain_log("basic", 8);
    check_all_drained("basic");
  endtask

  task automatic test_hang();
    clear_mon();
    for (int i = 0; i < NUM_IPS; i++) set_ip(i, -1, 1'b0, '0);
    set_ip(1, -1, 1'b1, 33'h1_2345_6789);
    push_exp(1, 1'b0, 1'b1, '0);
    pulse_start(16'd1, 4'b0010);
    wait_done("hang", 400);
    repeat (2) @(negedge clk);
    vectors++;
    if (en_cycles[1] !== ACK_TIMEOUT) begin
      miscompares++;
      $display("FAIL hang_enable_len: %0d cycles, expected %0d", en_cycles[1], ACK_TIMEOUT);
    end
    vectors++;
    if (hang_count !== 16'd1 || crash_count !== 16'd0) begin
      miscompares++;
      $display("FAIL hang_counts: hang=%0d crash=%0d, expected 1 0", hang_count, crash_count);
    end
    drain_log("hang", 8);
    check_all_drained("hang");
  endtask

  task automatic test_ack_at_expiry();
    clear_mon();
    set_ip(1, ACK_TIMEOUT, 1'b0, 33'h0_0BAD_F00D);
    push_exp(1, 1'b0, 1'b0, 33'h0_0BAD_F00D);
    pulse_start(16'd1, 4'b0010);
    wait_done("expiry", 400);
    repeat (2) @(negedge clk);
    vectors++;
    if (en_cycles[1] !== ACK_TIMEOUT || hang_count !== 16'd0) begin
      miscompares++;
      $display("FAIL expiry_ack_wins: enable_len=%0d hang=%0d, expected %0d 0",
               en_cycles[1], hang_count, ACK_TIMEOUT);
    end
    drain_log("expiry", 8);
    check_all_drained("expiry");
  endtask

  task automatic test_log_full();
    int k;
    clear_mon();
    for (int i = 0; i < NUM_IPS; i++) set_ip(i, 1, (i == 3), 33'(32'h100 + i));
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NUM_IPS; i++) push_exp(i, (i == 3), 1'b0, 33'(32'h100 + i));
    pulse_start(16'd3, 4'b1111);
    for (k = 0; k < 500 && !log_full; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    vectors++;
    if (log_full !== 1'b1 || busy !== 1'b1 || fz_enable !== '0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL full_stall: full=%b busy=%b enable=%b done_cnt=%0d, expected 1 1 0000 0",
               log_full, busy, fz_enable, done_cnt);
    end
    drain_log("full_pop4", 4);
    wait_done("full", 200);
    @(negedge clk);
    vectors++;
    if (crash_count !== 16'd3 || hang_count !== 16'd0 || log_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_counts: crash=%0d hang=%0d full=%b, expected 3 0 1", crash_count, hang_count, log_full);
    end
    drain_log("full_rest", 16);
    check_all_drained("full");
  endtask

  task automatic test_empty_campaigns();
    logic [15:0]        r_tab [2];
    logic [NUM_IPS-1:0] m_tab [2];
    r_tab[0] = 16'd0; m_tab[0] = 4'b1111;
    r_tab[1] = 16'd2; m_tab[1] = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      clear_mon();
      pulse_start(r_tab[c], m_tab[c]);
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL empty%0d_done: done=%b busy=%b, expected 1 0", c, done, busy);
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (done_cnt !== 1 || en_seen !== '0 || log_valid !== 1'b0 || crash_count !== 16'd0) begin
        miscompares++;
        $display("FAIL empty%0d_quiet: done_cnt=%0d en_seen=%b log_valid=%b crash=%0d, expected 1 0000 0 0",
                 c, done_cnt, en_seen, log_valid, crash_count);
      end
    end
  endtask

  task automatic test_start_while_busy();
    clear_mon();
    for (int i = 0; i < NUM_IPS; i++) set_ip(i, 1, 1'b0, '0);
    set_ip(0, 3, 1'b1, 33'h0_0000_00A0);
    set_ip(1, 20, 1'b0, 33'h0_0000_00A1);
    push_exp(0, 1'b1, 1'b0, 33'h0_0000_00A0);
    push_exp(1, 1'b0, 1'b0, 33'h0_0000_00A1);
    pulse_start(16'd1, 4'b0011);
    repeat (10) @(negedge clk);
    pulse_start(16'd5, 4'b1111);
    wait_done("busy_start", 200);
    repeat (3) @(negedge clk);
    vectors++;
    if (crash_count !== 16'd1 || done_cnt !== 1 || en_seen !== 4'b0011) begin
      miscompares++;
      $display("FAIL busy_start_ignored: crash=%0d done_cnt=%0d en_seen=%b, expected 1 1 0011",
               crash_count, done_cnt, en_seen);
    end
    drain_log("busy_start", 8);
    check_all_drained("busy_start");
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    for (int i = 0; i < NUM_IPS; i++) set_ip(i, -1, 1'b0, '0);
    set_ip(0, 2, 1'b0, 33'h0_0000_0007);
    pulse_start(16'd1, 4'b0011);
    for (k = 0; k < 50 && fz_enable !== 4'b0010; k++) @(negedge clk);
    vectors++;
    if (fz_enable !== 4'b0010 || log_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_setup: enable=%b log_valid=%b, expected 0010 1", fz_enable, log_valid);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (fz_enable !== '0 || log_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_immediate: enable=%b log_valid=%b busy=%b, expected 0 0 0", fz_enable, log_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt !== 0) begin
      miscompares++;
      $display("FAIL rstmid_no_done: done_cnt=%0d, expected 0", done_cnt);
    end
    exp_q.delete();
    clear_mon();
    set_ip(2, 4, 1'b0, 33'h0_0000_0ABC);
    push_exp(2, 1'b0, 1'b0, 33'h0_0000_0ABC);
    pulse_start(16'd1, 4'b0100);
    wait_done("rstmid_rerun", 100);
    @(negedge clk);
    vectors++;
    if (hang_count !== 16'd0 || crash_count !== 16'd0 || en_seen !== 4'b0100) begin
      miscompares++;
      $display("FAIL rstmid_rerun: hang=%0d crash=%0d en_seen=%b, expected 0 0 0100", hang_count, crash_count, en_seen);
    end
    drain_log("rstmid_rerun", 8);
    check_all_drained("rstmid_rerun");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hang();
    test_ack_at_expiry();
    test_log_full();
    test_empty_campaigns();
    test_start_while_busy();
    test_reset_mid();
    vectors++;
    if (onehot_bad !== 0) begin
      miscompares++;
      $display("FAIL enable_onehot: %0d cycles with >1 enable, expected 0", onehot_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/central_fuzzer_ctrl.md
Name: central_fuzzer_ctrl

Overview:
Central controller that drives up to NUM_IPS per-IP local fuzzers over the enable/ack/crash_detected/IP_output handshake; it is the other end of that handshake. It runs a campaign of N rounds, polling each unmasked IP in ascending index order. Each IP is enabled, its ack is awaited under a timeout, and its crash flag and 33-bit output are captured. Every result is pushed into a readable log FIFO, and crash and hang counts are kept.

Parameters:
NUM_IPS, 4, number of local fuzzer channels (1..16)
ACK_TIMEOUT, 255, max cycles in WAIT_ACK before the IP is declared hung (>=2)
LOG_DEPTH, 8, log FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; starts a campaign; ignored while busy
rounds  in  16  number of full passes over the mask; latched at start
ip_mask  in  NUM_IPS  bit i=1 means IP i is polled; latched at start
fz_enable  out  NUM_IPS  per-IP enable; at most one bit high
fz_ack  in  NUM_IPS  per-IP completion strobe (one cycle)
fz_crash  in  NUM_IPS  per-IP crash_detected level
fz_ip_output  in  NUM_IPS*33  per-IP 33-bit result; slice i = bits [33i+32:33i]
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at campaign end
crash_count  out  16  saturating count of crash results this campaign
hang_count  out  16  saturating count of timeouts this campaign
log_rd  in  1  pop the log head; ignored when log_valid=0
log_valid  out  1  log FIFO is not empty
log_ip  out  4  IP index of the head entry
log_crash  out  1  head entry crash flag
log_hang  out  1  head entry timeout flag
log_value  out  33  head entry captured fz_ip_output (0 when hang)
log_full  out  1  log FIFO is full

Behaviour:
- Reset (async, rst=1), immediate:
  - fz_enable=0, busy=0, done=0, counts=0.
  - FIFO emptied, so log_valid=0, log_full=0, and log_ip/log_crash/log_hang/log_value read 0.
  - State is IDLE. Reset mid-campaign aborts the campaign with no done pulse.
- States: IDLE, SELECT, WAIT_ACK, RECORD, DONE.
- IDLE: on start, latch rounds and ip_mask, clear crash_count and hang_count, go to SELECT.
  - If the latched rounds==0 or ip_mask==0, go to DONE instead.
- SELECT (1 cycle):
  - Pick the lowest set mask bit at index >= the current pointer.
  - If none remains, decrement the remaining-rounds count and restart the pointer at 0.
  - When the remaining-rounds count reaches 0, go to DONE.
  - Otherwise set fz_enable[sel] (registered) and go to WAIT_ACK.
- WAIT_ACK:
  - Timeout counter counts from 0. fz_enable[sel] stays high.
  - On fz_ack[sel]=1: capture fz_crash[sel] and the fz_ip_output slice in that same cycle, clear fz_enable on the next edge, go to RECORD.
  - The enable drop must coincide with the fuzzer's return to its idle state so that it does not re-launch.
  - If the counter reaches ACK_TIMEOUT-1 without ack: hang=1, crash=0, value=0, clear enable, go to RECORD.
  - If ack and expiry occur in the same cycle, ack wins.
  - Acks from non-selected IPs are ignored.
- RECORD:
  - Push {sel, crash, hang, value} if the log is not full. Otherwise stall in RECORD; no entry is ever dropped.
  - A log_rd in a stall cycle frees space; the push occurs the following cycle.
  - On push, increment crash_count or hang_count (saturate at 0xFFFF), advance the pointer to sel+1, go to SELECT.
- DONE: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- Timing: busy=1 in SELECT, WAIT_ACK and RECORD.
- Latency: start to first fz_enable high is 2 cycles (edge into SELECT, then the registered enable).
- Log FIFO: first-word fall-through, so the head is visible while log_valid=1.
  - A simultaneous push and pop when neither full nor empty are both performed.
  - Pointers wrap modulo LOG_DEPTH.

Decomposition:
- Package central_fuzzer_pkg holds:
  - the state enum;
  - the packed log entry struct {ip[3:0], crash, hang, value[32:0]};
  - localparam IP_OUT_W=33.
- Sub-module fuzz_log_fifo (parameter DEPTH; push/pop/full/empty/head).

Test Plan:
- Mask 4'b0101, rounds=1. IP0 acks after 5 cycles with crash=0 and value 33'h0_0000_0042; IP2 acks with crash=1 and value 33'h1_FFFF_FFFF. Required: 2 log entries in order (ip0,0,0,0x42) then (ip2,1,0,0x1FFFFFFFF); crash_count=1; done pulses once; IP1 and IP3 enables never rise.
- IP1 alone, never acks, ACK_TIMEOUT=255. Required: enable drops after 255 WAIT_ACK cycles; entry (ip1,0,1,0); hang_count=1.
- Ack on exactly the expiry cycle with crash=0. Required: entry hang=0, hang_count=0.
- LOG_DEPTH=8, mask 4'b1111, rounds=3, no reads. Required: the FSM stalls in RECORD after 8 entries and log_full=1. After 4 log_rd pops, the 12 entries arrive in order ip0..3 repeated three times.
- rounds=0 and, separately, mask=0. Required: done one cycle after SELECT is skipped, no enables, log empty. A start pulse while busy=1 is ignored and counts stay unchanged.
- rst asserted mid WAIT_ACK. Required: fz_enable=0 immediately, log_valid=0, no done pulse. A new start then runs normally.
